// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, state codes and
// the datapath mux/ALU select codes it drives.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      R_WB     = 4'd7,
      I_EXEC   = 4'd8,
      I_WB     = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      JAL      = 4'd12,
      TRAP     = 4'd13
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_EXC    = 2'b11;

   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle FSM (master) and the datapath (slave):
// IR opcode, ALU zero and memory ready in; mux selects and enables out.
interface mc_control_fsm_if #(
   parameter int OPCODE_W = 6
);
   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic                mem_ready;
   logic                pc_write;
   logic                iord;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          alu_op;
   logic [1:0]          mem_to_reg;
   logic                reg_write;
   logic [1:0]          reg_dst;
   logic [1:0]          pc_source;
   logic                illegal_op;
   logic                bus_err;
   logic [3:0]          state_o;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, iord, mem_read, mem_write, ir_write, alu_src_a,
             alu_src_b, alu_op, mem_to_reg, reg_write, reg_dst, pc_source,
             illegal_op, bus_err, state_o
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, iord, mem_read, mem_write, ir_write, alu_src_a,
             alu_src_b, alu_op, mem_to_reg, reg_write, reg_dst, pc_source,
             illegal_op, bus_err, state_o
   );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts cycles spent waiting on mem_ready in a memory state and flags a
// timeout once WAIT_MAX waiting cycles have elapsed.
module mc_wait_timer #(
   parameter int WAIT_MAX   = 15,
   parameter int WAIT_CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic busy,
   input  logic ready,
   output logic timeout
);

   logic [WAIT_CNT_W-1:0] count;

   // The count is zero on the first cycle of a waiting state because the FSM clears it on every state change.
   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (busy && !ready && !timeout)
         count <= count + WAIT_CNT_W'(1);
   end

   assign timeout = busy && (count == WAIT_CNT_W'(WAIT_MAX));

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory-ready timeout and illegal-opcode trapping.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OPCODE_W   = 6,
   parameter int WAIT_MAX   = 15,
   parameter int WAIT_CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   mc_control_fsm_if.master  bus
);

   state_t     state, state_next;
   logic       cause_illegal, cause_next;
   logic       wait_busy, wait_clr, timeout;
   logic [5:0] op;
   logic       op_high_nz;

   logic       pc_write, iord, mem_read, mem_write, ir_write, alu_src_a;
   logic       reg_write, illegal_op, bus_err;
   logic [1:0] alu_src_b, alu_op, mem_to_reg, reg_dst, pc_source;

   assign op         = bus.opcode[5:0];
   assign op_high_nz = |(bus.opcode >> 6);

   assign wait_busy = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
   assign wait_clr  = (state_next != state);

   mc_wait_timer #(
      .WAIT_MAX   (WAIT_MAX),
      .WAIT_CNT_W (WAIT_CNT_W)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (wait_clr),
      .busy    (wait_busy),
      .ready   (bus.mem_ready),
      .timeout (timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FETCH;
         cause_illegal <= 1'b0;
      end else begin
         state         <= state_next;
         cause_illegal <= cause_next;
      end
   end

   // mem_ready always beats a coinciding timeout in the waiting states.
   always_comb begin
      state_next = state;
      cause_next = cause_illegal;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALU_ADD;
      mem_to_reg = M2R_ALUOUT;
      reg_write  = 1'b0;
      reg_dst    = REGDST_RT;
      pc_source  = PCSRC_ALU;
      illegal_op = 1'b0;
      bus_err    = 1'b0;

      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (bus.mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = DECODE;
            end else if (timeout) begin
               state_next = TRAP;
               cause_next = 1'b0;
            end
         end
         DECODE: begin
            alu_src_b = SRCB_IMM_SH2;
            if (op_high_nz) begin
               state_next = TRAP;
               cause_next = 1'b1;
            end else begin
               case (op)
                  OP_RTYPE:      state_next = R_EXEC;
                  OP_LW, OP_SW:  state_next = MEM_ADDR;
                  OP_BEQ, OP_BNE: state_next = BRANCH;
                  OP_ADDI:       state_next = I_EXEC;
                  OP_J:          state_next = JUMP;
                  OP_JAL:        state_next = JAL;
                  default: begin
                     state_next = TRAP;
                     cause_next = 1'b1;
                  end
               endcase
            end
         end
         MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            state_next = (op == OP_LW) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (bus.mem_ready) begin
               state_next = MEM_WB;
            end else if (timeout) begin
               state_next = TRAP;
               cause_next = 1'b0;
            end
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_MDR;
            reg_dst    = REGDST_RT;
            state_next = FETCH;
         end
         MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (bus.mem_ready) begin
               state_next = FETCH;
            end else if (timeout) begin
               state_next = TRAP;
               cause_next = 1'b0;
            end
         end
         R_EXEC: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_FUNCT;
            state_next = R_WB;
         end
         R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = REGDST_RD;
            state_next = FETCH;
         end
         I_EXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALU_ADD;
            state_next = I_WB;
         end
         I_WB: begin
            reg_write  = 1'b1;
            reg_dst    = REGDST_RT;
            state_next = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_source  = PCSRC_ALUOUT;
            pc_write   = (op == OP_BNE) ? ~bus.zero : bus.zero;
            state_next = FETCH;
         end
         JUMP: begin
            pc_source  = PCSRC_JUMP;
            pc_write   = 1'b1;
            state_next = FETCH;
         end
         JAL: begin
            pc_source  = PCSRC_JUMP;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            reg_dst    = REGDST_RA;
            mem_to_reg = M2R_PC;
            state_next = FETCH;
         end
         TRAP: begin
            pc_source  = PCSRC_EXC;
            pc_write   = 1'b1;
            illegal_op = cause_illegal;
            bus_err    = ~cause_illegal;
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase

      if (rst) begin
         pc_write   = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         mem_to_reg = 2'b00;
         reg_write  = 1'b0;
         reg_dst    = 2'b00;
         pc_source  = 2'b00;
         illegal_op = 1'b0;
         bus_err    = 1'b0;
      end
   end

   assign bus.pc_write   = pc_write;
   assign bus.iord       = iord;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.ir_write   = ir_write;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.alu_op     = alu_op;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.reg_write  = reg_write;
   assign bus.reg_dst    = reg_dst;
   assign bus.pc_source  = pc_source;
   assign bus.illegal_op = illegal_op;
   assign bus.bus_err    = bus_err;
   assign bus.state_o    = rst ? 4'd0 : state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: each step queues the expected state and
// control word, and the negedge sample pops and compares it.
module tb_mc_control_fsm;
   import mc_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   typedef struct {
      string       tag;
      logic [22:0] exp;
   } sb_item_t;

   sb_item_t sb[$];

   mc_control_fsm_if #(.OPCODE_W(6)) bus ();

   mc_control_fsm #(
      .OPCODE_W   (6),
      .WAIT_MAX   (15),
      .WAIT_CNT_W (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no end of run, expected end before 100000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   // Packed word: {state, pc_write, iord, mem_read, mem_write, ir_write, alu_src_a,
   // alu_src_b, alu_op, mem_to_reg, reg_write, reg_dst, pc_source, illegal_op, bus_err}
   function automatic logic [22:0] exp_word(state_t st, logic pcw, logic irw,
                                            logic ill, logic berr);
      logic       e_iord, e_mr, e_mw, e_sa, e_rw;
      logic [1:0] e_sb, e_ao, e_m2r, e_rd, e_ps;
      e_iord = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_sa = 1'b0; e_rw = 1'b0;
      e_sb = 2'b00; e_ao = 2'b00; e_m2r = 2'b00; e_rd = 2'b00; e_ps = 2'b00;
      case (st)
         FETCH:    begin e_mr = 1'b1; e_sb = 2'b01; end
         DECODE:   e_sb = 2'b11;
         MEM_ADDR: begin e_sa = 1'b1; e_sb = 2'b10; end
         MEM_RD:   begin e_iord = 1'b1; e_mr = 1'b1; end
         MEM_WB:   begin e_rw = 1'b1; e_m2r = 2'b01; end
         MEM_WR:   begin e_iord = 1'b1; e_mw = 1'b1; end
         R_EXEC:   begin e_sa = 1'b1; e_ao = 2'b10; end
         R_WB:     begin e_rw = 1'b1; e_rd = 2'b01; end
         I_EXEC:   begin e_sa = 1'b1; e_sb = 2'b10; end
         I_WB:     e_rw = 1'b1;
         BRANCH:   begin e_sa = 1'b1; e_ao = 2'b01; e_ps = 2'b01; end
         JUMP:     e_ps = 2'b10;
         JAL:      begin e_ps = 2'b10; e_rw = 1'b1; e_rd = 2'b10; e_m2r = 2'b10; end
         TRAP:     e_ps = 2'b11;
         default:  ;
      endcase
      return {st, pcw, e_iord, e_mr, e_mw, irw, e_sa, e_sb, e_ao, e_m2r,
              e_rw, e_rd, e_ps, ill, berr};
   endfunction

   task automatic check_output();
      sb_item_t    item;
      logic [22:0] obs;
      obs = {bus.state_o, bus.pc_write, bus.iord, bus.mem_read, bus.mem_write,
             bus.ir_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
             bus.mem_to_reg, bus.reg_write, bus.reg_dst, bus.pc_source,
             bus.illegal_op, bus.bus_err};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("[TB] FAIL scoreboard_empty: observed %h, expected a queued entry", obs);
      end else begin
         item = sb.pop_front();
         assert (obs === item.exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
         end
      end
   endtask

   task automatic apply_stimulus(input string tag, input logic [5:0] op,
                                 input logic z, input logic rdy, input logic r,
                                 input state_t st, input logic pcw, input logic irw,
                                 input logic ill, input logic berr);
      sb_item_t item;
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = rdy;
      rst           = r;
      item.tag = tag;
      item.exp = r ? 23'd0 : exp_word(st, pcw, irw, ill, berr);
      sb.push_back(item);
      @(negedge clk);
      check_output();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_decode(input string tag, input logic [5:0] op);
      apply_stimulus({tag, "_fetch"},  op, 1'b0, 1'b1, 1'b0, FETCH,  1'b1, 1'b1, 1'b0, 1'b0);
      apply_stimulus({tag, "_decode"}, op, 1'b0, 1'b1, 1'b0, DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.opcode    = '0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;

      apply_stimulus("reset", 6'h00, 1'b0, 1'b1, 1'b1, FETCH, 1'b0, 1'b0, 1'b0, 1'b0);

      fetch_decode("lw", OP_LW);
      apply_stimulus("lw_addr", OP_LW, 1'b0, 1'b1, 1'b0, MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("lw_rd",   OP_LW, 1'b0, 1'b1, 1'b0, MEM_RD,   1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("lw_wb",   OP_LW, 1'b0, 1'b1, 1'b0, MEM_WB,   1'b0, 1'b0, 1'b0, 1'b0);

      fetch_decode("beq_nt", OP_BEQ);
      apply_stimulus("beq_nt_branch", OP_BEQ, 1'b0, 1'b1, 1'b0, BRANCH, 1'b0, 1'b0, 1'b0, 1'b0);
      fetch_decode("bne_t", OP_BNE);
      apply_stimulus("bne_t_branch", OP_BNE, 1'b0, 1'b1, 1'b0, BRANCH, 1'b1, 1'b0, 1'b0, 1'b0);
      fetch_decode("beq_t", OP_BEQ);
      apply_stimulus("beq_t_branch", OP_BEQ, 1'b1, 1'b1, 1'b0, BRANCH, 1'b1, 1'b0, 1'b0, 1'b0);
      fetch_decode("bne_nt", OP_BNE);
      apply_stimulus("bne_nt_branch", OP_BNE, 1'b1, 1'b1, 1'b0, BRANCH, 1'b0, 1'b0, 1'b0, 1'b0);

      fetch_decode("jal", OP_JAL);
      apply_stimulus("jal_exec", OP_JAL, 1'b0, 1'b1, 1'b0, JAL, 1'b1, 1'b0, 1'b0, 1'b0);
      fetch_decode("j", OP_J);
      apply_stimulus("j_exec", OP_J, 1'b0, 1'b1, 1'b0, JUMP, 1'b1, 1'b0, 1'b0, 1'b0);

      fetch_decode("rtype", OP_RTYPE);
      apply_stimulus("rtype_exec", OP_RTYPE, 1'b0, 1'b1, 1'b0, R_EXEC, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("rtype_wb",   OP_RTYPE, 1'b0, 1'b1, 1'b0, R_WB,   1'b0, 1'b0, 1'b0, 1'b0);
      fetch_decode("addi", OP_ADDI);
      apply_stimulus("addi_exec", OP_ADDI, 1'b0, 1'b1, 1'b0, I_EXEC, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("addi_wb",   OP_ADDI, 1'b0, 1'b1, 1'b0, I_WB,   1'b0, 1'b0, 1'b0, 1'b0);

      fetch_decode("illegal", 6'b111111);
      apply_stimulus("illegal_trap", 6'b111111, 1'b0, 1'b1, 1'b0, TRAP, 1'b1, 1'b0, 1'b1, 1'b0);

      apply_stimulus("fetch_wait0", OP_SW, 1'b0, 1'b0, 1'b0, FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("fetch_wait1", OP_SW, 1'b0, 1'b0, 1'b0, FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
      fetch_decode("sw_wait", OP_SW);
      apply_stimulus("sw_wait_addr", OP_SW, 1'b0, 1'b1, 1'b0, MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         apply_stimulus($sformatf("sw_wait_wr%0d", i), OP_SW, 1'b0, 1'b0, 1'b0, MEM_WR,
                        1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("sw_wait_wr_done", OP_SW, 1'b0, 1'b1, 1'b0, MEM_WR, 1'b0, 1'b0, 1'b0, 1'b0);

      fetch_decode("sw_to", OP_SW);
      apply_stimulus("sw_to_addr", OP_SW, 1'b0, 1'b1, 1'b0, MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++)
         apply_stimulus($sformatf("sw_to_wr%0d", i), OP_SW, 1'b0, 1'b0, 1'b0, MEM_WR,
                        1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("sw_to_trap", OP_SW, 1'b0, 1'b0, 1'b0, TRAP, 1'b1, 1'b0, 1'b0, 1'b1);

      fetch_decode("lw_edge", OP_LW);
      apply_stimulus("lw_edge_addr", OP_LW, 1'b0, 1'b1, 1'b0, MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++)
         apply_stimulus($sformatf("lw_edge_rd%0d", i), OP_LW, 1'b0, 1'b0, 1'b0, MEM_RD,
                        1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("lw_edge_rd_ready", OP_LW, 1'b0, 1'b1, 1'b0, MEM_RD, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("lw_edge_wb",       OP_LW, 1'b0, 1'b1, 1'b0, MEM_WB, 1'b0, 1'b0, 1'b0, 1'b0);

      fetch_decode("lw_rst", OP_LW);
      apply_stimulus("lw_rst_addr", OP_LW, 1'b0, 1'b1, 1'b0, MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("lw_rst_rd0",  OP_LW, 1'b0, 1'b0, 1'b0, MEM_RD,   1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("lw_rst_rd1",  OP_LW, 1'b0, 1'b0, 1'b0, MEM_RD,   1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("mid_reset",   OP_LW, 1'b0, 1'b1, 1'b1, FETCH,    1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++)
         apply_stimulus($sformatf("fetch_to%0d", i), OP_LW, 1'b0, 1'b0, 1'b0, FETCH,
                        1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus("fetch_to_trap", OP_LW, 1'b0, 1'b0, 1'b0, TRAP, 1'b1, 1'b0, 1'b0, 1'b1);

      fetch_decode("illegal2", 6'b010000);
      apply_stimulus("illegal2_trap", 6'b010000, 1'b0, 1'b1, 1'b0, TRAP, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus("final_fetch", OP_J, 1'b0, 1'b1, 1'b0, FETCH, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multicycle control FSM for the MIPS-style datapath. It sequences fetch, decode, execute, memory and writeback, and decodes R-type, LW, SW, BEQ, BNE, ADDI, J and JAL. It waits on a memory ready handshake with a timeout, and traps illegal opcodes and memory timeouts to an exception vector. It sits between the instruction register opcode field and the datapath muxes and enables.

Parameters:
OPCODE_W, 6, opcode field width. Bits above [5:0] must be zero for a legal opcode.
WAIT_MAX, 15, maximum cycles a memory state waits for mem_ready before a bus-error trap; range 1..255.
WAIT_CNT_W, 8, width of the wait counter; must satisfy WAIT_MAX < 2**WAIT_CNT_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  OPCODE_W  instruction opcode from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  PC load enable, branch condition already resolved
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC (link)
reg_write  out  1  register file write enable
reg_dst  out  2  00=rt, 01=rd, 10=$31
pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=exception vector
illegal_op  out  1  one-cycle pulse in TRAP caused by decode
bus_err  out  1  one-cycle pulse in TRAP caused by memory timeout
state_o  out  4  current state encoding, for debug

Behaviour:
- Moore-style decode from state. The only Mealy terms are mem_ready, which gates the write enables in memory states, and zero, which drives pc_write in BRANCH.
- rst sampled high: state becomes FETCH and the wait counter clears at the edge. While rst is high, every output is forced to 0. After reset, state_o=FETCH.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, TRAP.
- FETCH: mem_read=1, alu_src_b=01. When mem_ready=1: ir_write=1, pc_write=1, next state DECODE. Otherwise hold in FETCH with both enables at 0.
- DECODE: alu_src_b=11 (branch target precompute). Opcode routing:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 001000 -> I_EXEC
  - 000010 -> JUMP
  - 000011 -> JAL
  - anything else, or any nonzero bit above [5:0] -> TRAP with illegal cause
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Next state MEM_RD for LW, MEM_WR for SW. The opcode is stable from IR.
- MEM_RD: iord=1, mem_read=1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=01, reg_dst=00. Next state FETCH.
- MEM_WR: iord=1, mem_write=1 held until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_op=10. Next R_WB.
- R_WB: reg_write=1, reg_dst=01. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next I_WB.
- I_WB: reg_write=1, reg_dst=00. Next FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_source=01. pc_write = zero for BEQ, ~zero for BNE. Next FETCH.
- JUMP: pc_source=10, pc_write=1. Next FETCH.
- JAL: pc_source=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10. Next FETCH.
- TRAP: pc_source=11, pc_write=1, and exactly one of illegal_op or bus_err pulses high. Next FETCH.
- Wait counter: clears on entry to FETCH, MEM_RD or MEM_WR, and increments each cycle spent there without mem_ready.
  - If the count equals WAIT_MAX and mem_ready=0: next state TRAP with bus_err cause. No ir_write, reg_write or pc_write happens from the memory state.
  - If mem_ready and timeout coincide, mem_ready wins.
- Latency at zero wait states (mem_ready tied high), counted from entering FETCH to re-entering FETCH: R/ADDI 4, LW 5, SW 4, BEQ/BNE/J/JAL 3, illegal 3.
- Cause register: a 1-bit register set in DECODE or the memory state selects which pulse fires in TRAP.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode localparams
  - state encoding (4-bit)
  - alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg codes
- Sub-module mc_wait_timer (parameters WAIT_MAX, WAIT_CNT_W; inputs clk, rst, clr, busy, ready; output timeout) holds the wait counter.
- Everything else stays in mc_control_fsm.

Test Plan:
- Reset then LW, opcode=100011, mem_ready=1 -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB,FETCH. reg_write=1 with mem_to_reg=01 only in MEM_WB.
- BEQ with zero=0 -> pc_write=0 in BRANCH. BNE with zero=0 -> pc_write=1 and pc_source=01.
- JAL, opcode=000011 -> in a single cycle, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10. Back in FETCH after 3 cycles.
- Opcode=111111 -> DECODE goes to TRAP. illegal_op pulses once, pc_source=11. bus_err stays 0.
- SW with mem_ready low for 3 cycles, WAIT_MAX=15 -> mem_write held 4 cycles, then FETCH. With mem_ready held low -> TRAP after 15 waiting cycles (16 in MEM_WR), bus_err pulses.
- rst asserted mid-MEM_RD -> all outputs 0 during reset. Next state FETCH, wait counter cleared.
